// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage.
// Contents:
//   - ALU function codes driven to the ALU
//   - MIPS opcode and R-type funct constants used by the decoder
//   - the issue-control state encoding
//   - the operand bundle carried from decode into the EX-side registers
//   - immediate extension helpers
package alu_issue_stage_pkg;

   // ALU function codes
   localparam logic [5:0] FUN_ADD = 6'b000000;
   localparam logic [5:0] FUN_SUB = 6'b000001;
   localparam logic [5:0] FUN_AND = 6'b011000;
   localparam logic [5:0] FUN_OR  = 6'b011110;
   localparam logic [5:0] FUN_XOR = 6'b010110;
   localparam logic [5:0] FUN_NOR = 6'b010001;
   localparam logic [5:0] FUN_STA = 6'b011010;
   localparam logic [5:0] FUN_SLL = 6'b100000;
   localparam logic [5:0] FUN_SRL = 6'b100001;
   localparam logic [5:0] FUN_SRA = 6'b100011;
   localparam logic [5:0] FUN_EQ  = 6'b110011;
   localparam logic [5:0] FUN_NEQ = 6'b110001;
   localparam logic [5:0] FUN_LT  = 6'b110101;
   localparam logic [5:0] FUN_LEZ = 6'b111101;
   localparam logic [5:0] FUN_GEZ = 6'b111001;
   localparam logic [5:0] FUN_GTZ = 6'b111111;

   // Opcodes
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // R-type funct field values
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // Issue control: output register empty / output held / output and skid held
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } issueState_t;

   // Everything the ALU and writeback need for one instruction
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  aluFun;
      logic        sign;
      logic [4:0]  rd;
      logic        regWrite;
      logic        illegal;
   } aluBundle_t;

   function automatic logic [31:0] signExt16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   function automatic logic [31:0] zeroExt16(input logic [15:0] imm);
      return {16'h0000, imm};
   endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational MIPS decoder for the ALU issue stage.
// Ports:
//   inst    in  32  instruction word
//   rsData  in  32  GPR[rs]
//   rtData  in  32  GPR[rt]
//   bundle  out     operands, ALU function, sign select, destination, write enable, illegal flag
// Parameter TRAP_ILL: 1 flags unknown encodings as illegal, 0 issues them silently as a NOP.
module alu_issue_stage_decode
   import alu_issue_stage_pkg::*;
#(
   parameter bit TRAP_ILL = 1'b1
) (
   input  logic [31:0] inst,
   input  logic [31:0] rsData,
   input  logic [31:0] rtData,
   output aluBundle_t  bundle
);

   logic [5:0]  opcode;
   logic [4:0]  rtField;
   logic [4:0]  rdField;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic        unusedRsField;

   assign opcode  = inst[31:26];
   assign rtField = inst[20:16];
   assign rdField = inst[15:11];
   assign shamt   = inst[10:6];
   assign funct   = inst[5:0];
   assign imm     = inst[15:0];

   // The rs register number is resolved by the register file; only its data arrives here.
   assign unusedRsField = ^inst[25:21];

   // Decode into a bundle. Anything not recognised collapses to ADD 0+0 with no write,
   // and a zero destination always suppresses the write.
   always_comb begin
      logic known;
      known           = 1'b1;
      bundle          = '0;
      bundle.a        = rsData;
      bundle.b        = rtData;
      bundle.aluFun   = FUN_ADD;
      bundle.rd       = rtField;
      bundle.regWrite = 1'b1;

      case (opcode)
         OP_RTYPE: begin
            bundle.rd = rdField;
            case (funct)
               FN_ADD:  begin bundle.aluFun = FUN_ADD; bundle.sign = 1'b1; end
               FN_ADDU: bundle.aluFun = FUN_ADD;
               FN_SUB:  begin bundle.aluFun = FUN_SUB; bundle.sign = 1'b1; end
               FN_SUBU: bundle.aluFun = FUN_SUB;
               FN_AND:  bundle.aluFun = FUN_AND;
               FN_OR:   bundle.aluFun = FUN_OR;
               FN_XOR:  bundle.aluFun = FUN_XOR;
               FN_NOR:  bundle.aluFun = FUN_NOR;
               FN_SLT:  begin bundle.aluFun = FUN_LT; bundle.sign = 1'b1; end
               FN_SLTU: bundle.aluFun = FUN_LT;
               FN_SLL:  begin bundle.aluFun = FUN_SLL; bundle.a = {27'b0, shamt}; end
               FN_SRL:  begin bundle.aluFun = FUN_SRL; bundle.a = {27'b0, shamt}; end
               FN_SRA:  begin bundle.aluFun = FUN_SRA; bundle.a = {27'b0, shamt}; end
               FN_JR:   begin bundle.aluFun = FUN_STA; bundle.regWrite = 1'b0; end
               default: known = 1'b0;
            endcase
         end
         OP_REGIMM: begin
            bundle.b        = '0;
            bundle.sign     = 1'b1;
            bundle.regWrite = 1'b0;
            case (rtField)
               5'd0:    bundle.aluFun = FUN_LT;
               5'd1:    bundle.aluFun = FUN_GEZ;
               default: known = 1'b0;
            endcase
         end
         OP_BEQ:  begin bundle.aluFun = FUN_EQ;  bundle.regWrite = 1'b0; end
         OP_BNE:  begin bundle.aluFun = FUN_NEQ; bundle.regWrite = 1'b0; end
         OP_BLEZ: begin
            bundle.aluFun = FUN_LEZ; bundle.b = '0; bundle.sign = 1'b1; bundle.regWrite = 1'b0;
         end
         OP_BGTZ: begin
            bundle.aluFun = FUN_GTZ; bundle.b = '0; bundle.sign = 1'b1; bundle.regWrite = 1'b0;
         end
         OP_ADDI:  begin bundle.b = signExt16(imm); bundle.sign = 1'b1; end
         OP_ADDIU: bundle.b = signExt16(imm);
         OP_SLTI:  begin bundle.aluFun = FUN_LT; bundle.b = signExt16(imm); bundle.sign = 1'b1; end
         OP_SLTIU: begin bundle.aluFun = FUN_LT; bundle.b = signExt16(imm); end
         OP_ANDI:  begin bundle.aluFun = FUN_AND; bundle.b = zeroExt16(imm); end
         OP_ORI:   begin bundle.aluFun = FUN_OR;  bundle.b = zeroExt16(imm); end
         OP_XORI:  begin bundle.aluFun = FUN_XOR; bundle.b = zeroExt16(imm); end
         // lui is a left shift of the zero-extended immediate by 16
         OP_LUI:   begin bundle.aluFun = FUN_SLL; bundle.a = 32'd16; bundle.b = zeroExt16(imm); end
         OP_LW:    begin bundle.b = signExt16(imm); bundle.sign = 1'b1; end
         OP_SW:    begin bundle.b = signExt16(imm); bundle.sign = 1'b1; bundle.regWrite = 1'b0; end
         default:  known = 1'b0;
      endcase

      if (!known) begin
         bundle         = '0;
         bundle.aluFun  = FUN_ADD;
         bundle.illegal = TRAP_ILL;
      end

      if (bundle.rd == 5'd0) begin
         bundle.regWrite = 1'b0;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an instruction, registers the ALU operand bundle into EX,
// with a 2-entry (output + skid) buffer so oInstReady can be a register.
// Ports:
//   iClk, iRst                 clock, synchronous active-high reset
//   iInstValid/oInstReady      upstream handshake; iInst, iRsData, iRtData payload
//   iFlush                     discard all held bundles and this cycle's input
//   oExValid/iExReady          downstream handshake
//   oA, oB, oALUFun, oSign     ALU operands and function
//   oRd, oRegWrite, oIllegal   writeback destination, enable, undecodable flag
//   oStallCnt                  saturating count of cycles with oExValid & !iExReady
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter bit TRAP_ILL = 1'b1
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iInstValid,
   output logic             oInstReady,
   input  logic [31:0]      iInst,
   input  logic [31:0]      iRsData,
   input  logic [31:0]      iRtData,
   input  logic             iFlush,
   output logic             oExValid,
   input  logic             iExReady,
   output logic [31:0]      oA,
   output logic [31:0]      oB,
   output logic [5:0]       oALUFun,
   output logic             oSign,
   output logic [4:0]       oRd,
   output logic             oRegWrite,
   output logic             oIllegal,
   output logic [CNT_W-1:0] oStallCnt
);

   issueState_t      state;
   aluBundle_t       decoded;
   aluBundle_t       outReg;
   aluBundle_t       skidReg;
   logic             readyReg;
   logic [CNT_W-1:0] stallCnt;
   logic             accept;
   logic             transfer;

   alu_issue_stage_decode #(
      .TRAP_ILL(TRAP_ILL)
   ) decodeUnit (
      .inst   (iInst),
      .rsData (iRsData),
      .rtData (iRtData),
      .bundle (decoded)
   );

   assign accept   = iInstValid & readyReg;
   assign transfer = (state != ST_EMPTY) & iExReady;

   // Issue control. The ready flag is registered alongside the state so it always
   // equals (state != SKID) outside reset; while reset is held it stays low.
   // A flush empties both entries and drops whatever is offered in that cycle.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state    <= ST_EMPTY;
         readyReg <= 1'b0;
         outReg   <= '0;
         skidReg  <= '0;
      end else if (iFlush) begin
         state    <= ST_EMPTY;
         readyReg <= 1'b1;
         skidReg  <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  outReg <= decoded;
                  state  <= ST_FULL;
               end
               readyReg <= 1'b1;
            end
            ST_FULL: begin
               if (accept && transfer) begin
                  outReg   <= decoded;
                  readyReg <= 1'b1;
               end else if (accept) begin
                  skidReg  <= decoded;
                  state    <= ST_SKID;
                  readyReg <= 1'b0;
               end else if (transfer) begin
                  state    <= ST_EMPTY;
                  readyReg <= 1'b1;
               end
            end
            ST_SKID: begin
               if (transfer) begin
                  outReg   <= skidReg;
                  state    <= ST_FULL;
                  readyReg <= 1'b1;
               end
            end
            default: begin
               state    <= ST_EMPTY;
               readyReg <= 1'b1;
            end
         endcase
      end
   end

   // Stall counter survives flushes and sticks at all-ones.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         stallCnt <= '0;
      end else if ((state != ST_EMPTY) && !iExReady && (stallCnt != {CNT_W{1'b1}})) begin
         stallCnt <= stallCnt + 1'b1;
      end
   end

   assign oInstReady = readyReg;
   assign oExValid   = (state != ST_EMPTY);
   assign oA         = outReg.a;
   assign oB         = outReg.b;
   assign oALUFun    = outReg.aluFun;
   assign oSign      = outReg.sign;
   assign oRd        = outReg.rd;
   assign oRegWrite  = outReg.regWrite;
   assign oIllegal   = outReg.illegal;
   assign oStallCnt  = stallCnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed instructions, each with a hand-derived
// expected bundle queued on acceptance and compared in order when the EX side takes it.
module tb_alu_issue_stage;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  fun;
      logic        sign;
      logic [4:0]  rd;
      logic        regWrite;
      logic        illegal;
   } bundleT;

   logic        iClk = 1'b0;
   logic        iRst;
   logic        iInstValid;
   logic        oInstReady;
   logic [31:0] iInst;
   logic [31:0] iRsData;
   logic [31:0] iRtData;
   logic        iFlush;
   logic        oExValid;
   logic        iExReady;
   logic [31:0] oA;
   logic [31:0] oB;
   logic [5:0]  oALUFun;
   logic        oSign;
   logic [4:0]  oRd;
   logic        oRegWrite;
   logic        oIllegal;
   logic [15:0] oStallCnt;

   int compared   = 0;
   int mismatched = 0;

   bundleT expQ[$];
   string  nameQ[$];
   bundleT pendExp;
   string  pendName;

   alu_issue_stage #(
      .CNT_W    (16),
      .TRAP_ILL (1'b1)
   ) dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iInstValid (iInstValid),
      .oInstReady (oInstReady),
      .iInst      (iInst),
      .iRsData    (iRsData),
      .iRtData    (iRtData),
      .iFlush     (iFlush),
      .oExValid   (oExValid),
      .iExReady   (iExReady),
      .oA         (oA),
      .oB         (oB),
      .oALUFun    (oALUFun),
      .oSign      (oSign),
      .oRd        (oRd),
      .oRegWrite  (oRegWrite),
      .oIllegal   (oIllegal),
      .oStallCnt  (oStallCnt)
   );

   always #5 iClk = ~iClk;

   function automatic bundleT mkExp(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fun,
                                    input logic sign, input logic [4:0] rd, input logic wr,
                                    input logic ill);
      bundleT e;
      e.a = a; e.b = b; e.fun = fun; e.sign = sign; e.rd = rd; e.regWrite = wr; e.illegal = ill;
      return e;
   endfunction

   function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // One comparison; the failure counter is the one printed in the summary.
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock. Handshakes are evaluated just before the edge: a flush clears the
   // scoreboard, a transfer pops and compares, an accept pushes the pending expectation.
   task automatic tick(output bit acc);
      bit     xfer;
      bundleT obsB;
      bundleT e;
      string  n;
      xfer = oExValid && iExReady && !iFlush;
      acc  = iInstValid && oInstReady && !iFlush;
      obsB = {oA, oB, oALUFun, oSign, oRd, oRegWrite, oIllegal};
      if (iFlush) begin
         expQ.delete();
         nameQ.delete();
      end else begin
         if (xfer) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedBundle", {127'b0, oExValid}, 128'd0);
            end else begin
               e = expQ.pop_front();
               n = nameQ.pop_front();
               checkOutput(n, {50'b0, obsB}, {50'b0, e});
            end
         end
         if (acc) begin
            expQ.push_back(pendExp);
            nameQ.push_back(pendName);
         end
      end
      @(posedge iClk);
      #1;
   endtask

   // Offer one instruction and hold it until accepted (bounded).
   task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt,
                                input bundleT exp, input string name);
      bit acc;
      iInstValid = 1'b1;
      iInst      = inst;
      iRsData    = rs;
      iRtData    = rt;
      pendExp    = exp;
      pendName   = name;
      acc        = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         tick(acc);
      end
      if (!acc) begin
         checkOutput({"acceptTimeout_", name}, {127'b0, oInstReady}, 128'd1);
      end
      iInstValid = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      iExReady = 1'b1;
      for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
         tick(acc);
      end
      checkOutput("drainQueueEmpty", 128'(expQ.size()), 128'd0);
      checkOutput("drainExValid", {127'b0, oExValid}, 128'd0);
   endtask

   initial begin
      bit acc;
      iRst       = 1'b1;
      iInstValid = 1'b0;
      iInst      = '0;
      iRsData    = '0;
      iRtData    = '0;
      iFlush     = 1'b0;
      iExReady   = 1'b1;
      pendExp    = '0;
      pendName   = "none";

      repeat (3) @(posedge iClk);
      #1;
      $display("[TB] reset checks");
      checkOutput("resetInstReady", {127'b0, oInstReady}, 128'd0);
      checkOutput("resetExValid", {127'b0, oExValid}, 128'd0);
      checkOutput("resetBundle", {50'b0, oA, oB, oALUFun, oSign, oRd, oRegWrite, oIllegal}, 128'd0);
      checkOutput("resetStallCnt", {112'b0, oStallCnt}, 128'd0);
      iRst = 1'b0;
      tick(acc);
      checkOutput("readyAfterReset", {127'b0, oInstReady}, 128'd1);

      $display("[TB] decode sequence, EX always ready");
      applyStimulus(rType(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7,
                    mkExp(32'd5, 32'd7, 6'b000000, 1'b1, 5'd3, 1'b1, 1'b0), "add");
      checkOutput("addLatencyExValid", {127'b0, oExValid}, 128'd1);
      applyStimulus(iType(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd10, 32'd0,
                    mkExp(32'd10, 32'hFFFF_FFFF, 6'b000000, 1'b1, 5'd4, 1'b1, 1'b0), "addi");
      applyStimulus(iType(6'h0D, 5'd2, 5'd5, 16'hFFFF), 32'h1234_0000, 32'd0,
                    mkExp(32'h1234_0000, 32'h0000_FFFF, 6'b011110, 1'b0, 5'd5, 1'b1, 1'b0), "ori");
      applyStimulus(iType(6'h0F, 5'd0, 5'd6, 16'h1234), 32'hDEAD_BEEF, 32'd0,
                    mkExp(32'd16, 32'h0000_1234, 6'b100000, 1'b0, 5'd6, 1'b1, 1'b0), "lui");
      applyStimulus(rType(5'd0, 5'd1, 5'd7, 5'd4, 6'h00), 32'd99, 32'd1,
                    mkExp(32'd4, 32'd1, 6'b100000, 1'b0, 5'd7, 1'b1, 1'b0), "sll");
      applyStimulus(iType(6'h3F, 5'd1, 5'd2, 16'h5555), 32'd3, 32'd4,
                    mkExp(32'd0, 32'd0, 6'b000000, 1'b0, 5'd0, 1'b0, 1'b1), "illegalOp3F");
      applyStimulus(iType(6'h04, 5'd1, 5'd2, 16'd3), 32'd9, 32'd9,
                    mkExp(32'd9, 32'd9, 6'b110011, 1'b0, 5'd2, 1'b0, 1'b0), "beq");
      applyStimulus(iType(6'h2B, 5'd3, 5'd4, 16'h0008), 32'd100, 32'd55,
                    mkExp(32'd100, 32'd8, 6'b000000, 1'b1, 5'd4, 1'b0, 1'b0), "sw");
      applyStimulus(rType(5'd1, 5'd2, 5'd0, 5'd0, 6'h22), 32'd8, 32'd3,
                    mkExp(32'd8, 32'd3, 6'b000001, 1'b1, 5'd0, 1'b0, 1'b0), "subRdZero");
      applyStimulus(iType(6'h01, 5'd4, 5'd0, 16'h0010), 32'hFFFF_FFFE, 32'd77,
                    mkExp(32'hFFFF_FFFE, 32'd0, 6'b110101, 1'b1, 5'd0, 1'b0, 1'b0), "bltz");
      applyStimulus(rType(5'd0, 5'd2, 5'd8, 5'd31, 6'h03), 32'd1, 32'h8000_0000,
                    mkExp(32'd31, 32'h8000_0000, 6'b100011, 1'b0, 5'd8, 1'b1, 1'b0), "sra");
      drain();

      $display("[TB] back-to-back with EX stalled");
      iExReady = 1'b0;
      applyStimulus(iType(6'h0E, 5'd1, 5'd9, 16'h00F0), 32'h0000_0F0F, 32'd0,
                    mkExp(32'h0000_0F0F, 32'h0000_00F0, 6'b010110, 1'b0, 5'd9, 1'b1, 1'b0), "stallXori");
      applyStimulus(rType(5'd1, 5'd2, 5'd10, 5'd0, 6'h27), 32'h0F0F_0F0F, 32'h00FF_00FF,
                    mkExp(32'h0F0F_0F0F, 32'h00FF_00FF, 6'b010001, 1'b0, 5'd10, 1'b1, 1'b0), "stallNor");
      checkOutput("readyLowAfterTwo", {127'b0, oInstReady}, 128'd0);
      iInstValid = 1'b1;
      iInst      = rType(5'd1, 5'd2, 5'd11, 5'd0, 6'h2B);
      iRsData    = 32'd1;
      iRtData    = 32'hFFFF_FFFF;
      pendExp    = mkExp(32'd1, 32'hFFFF_FFFF, 6'b110101, 1'b0, 5'd11, 1'b1, 1'b0);
      pendName   = "stallSltu";
      tick(acc);
      tick(acc);
      checkOutput("stallCnt3", {112'b0, oStallCnt}, 128'd3);
      checkOutput("stallHoldExValid", {127'b0, oExValid}, 128'd1);
      iExReady = 1'b1;
      applyStimulus(iInst, iRsData, iRtData, pendExp, pendName);
      drain();
      checkOutput("stallCntKept", {112'b0, oStallCnt}, 128'd3);

      $display("[TB] flush from SKID and from FULL");
      iExReady = 1'b0;
      applyStimulus(iType(6'h09, 5'd1, 5'd12, 16'h0001), 32'd1, 32'd0,
                    mkExp(32'd1, 32'd1, 6'b000000, 1'b0, 5'd12, 1'b1, 1'b0), "flushedA");
      applyStimulus(iType(6'h0C, 5'd1, 5'd13, 16'h00FF), 32'd7, 32'd0,
                    mkExp(32'd7, 32'h0000_00FF, 6'b011000, 1'b0, 5'd13, 1'b1, 1'b0), "flushedB");
      checkOutput("skidReadyLow", {127'b0, oInstReady}, 128'd0);
      iInstValid = 1'b1;
      iInst      = rType(5'd1, 5'd2, 5'd14, 5'd0, 6'h21);
      iFlush     = 1'b1;
      tick(acc);
      iFlush     = 1'b0;
      iInstValid = 1'b0;
      checkOutput("flushSkidExValid", {127'b0, oExValid}, 128'd0);
      checkOutput("flushSkidReady", {127'b0, oInstReady}, 128'd1);
      applyStimulus(iType(6'h0A, 5'd1, 5'd15, 16'h8000), 32'd0, 32'd0,
                    mkExp(32'd0, 32'hFFFF_8000, 6'b110101, 1'b1, 5'd15, 1'b1, 1'b0), "flushedC");
      iInstValid = 1'b1;
      iInst      = rType(5'd1, 5'd2, 5'd16, 5'd0, 6'h25);
      iFlush     = 1'b1;
      tick(acc);
      iFlush     = 1'b0;
      iInstValid = 1'b0;
      checkOutput("flushFullExValid", {127'b0, oExValid}, 128'd0);
      iExReady = 1'b1;
      applyStimulus(iType(6'h07, 5'd5, 5'd0, 16'h0004), 32'd42, 32'd0,
                    mkExp(32'd42, 32'd0, 6'b111111, 1'b1, 5'd0, 1'b0, 1'b0), "bgtzAfterFlush");
      applyStimulus(rType(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 32'h0040_0000, 32'd0,
                    mkExp(32'h0040_0000, 32'd0, 6'b011010, 1'b0, 5'd0, 1'b0, 1'b0), "jr");
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
